// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage.
//
// Holds the program counter and fetches one 32-bit instruction at a time
// from instruction memory over a req/ack handshake. The fetched word is
// handed to decode over a valid/ready handshake. A redirect (taken branch,
// J/JAL/JR target) replaces sequential PC+4 flow and squashes any in-flight
// fetch.
//
// Ports
//   CLK, RST           clock (rising edge), async active-low reset
//   Imem_Req/Addr      fetch request and byte address to instruction memory
//   Imem_Ack/Rdata     memory response; Rdata valid only with Ack
//   Ins, PC_Out, PC4   instruction to decode, its address, and address+4
//   Ins_Valid/Ready    decode handshake
//   Redirect/_Target   new fetch PC; target bits [1:0] are ignored
//
// All outputs come from flops or from the state register only.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Rdata,
    output logic [31:0] Ins,
    output logic        Ins_Valid,
    input  logic        Ins_Ready,
    output logic [31:0] PC_Out,
    output logic [31:0] PC4,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // address of the current/next fetch
    logic [31:0] tgt_q, tgt_d;        // redirect target saved while draining
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] redir_pc;

    assign redir_pc = {Redirect_Target[31:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        ins_d    = ins_q;
        pc_out_d = pc_out_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (Imem_Ack && !Redirect) begin
                    ins_d    = Imem_Rdata;
                    pc_out_d = pc_q;
                    state_d  = S_HOLD;
                end else if (Imem_Ack && Redirect) begin
                    // Response belongs to the squashed path; refetch at target.
                    pc_d = redir_pc;
                end else if (Redirect) begin
                    // Request is outstanding and cannot be withdrawn.
                    tgt_d   = redir_pc;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (Redirect) begin
                    pc_d    = redir_pc;
                    state_d = S_FETCH;
                end else if (Ins_Ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (Redirect) tgt_d = redir_pc;
                if (Imem_Ack) begin
                    // Latest redirect wins, including one on the ack edge.
                    pc_d    = Redirect ? redir_pc : tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            tgt_q    <= 32'h0;
            ins_q    <= 32'h0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            ins_q    <= ins_d;
            pc_out_q <= pc_out_d;
        end
    end

    // pc_q only moves on an ack or outside a request, so the address is
    // held for the whole life of a request.
    assign Imem_Req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign Imem_Addr = pc_q;
    assign Ins       = ins_q;
    assign Ins_Valid = (state_q == S_HOLD);
    assign PC_Out    = pc_out_q;
    assign PC4       = pc_out_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A transaction-level model (request outstanding / squash pending / word
// held for decode) tracks what the outputs must be; one compare process
// checks them on every falling edge. Directed sequences pin the model with
// literal expectations, then a randomized phase exercises everything.
// Memory data is derived from the address xor a key so each word differs.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Rdata;
    logic [31:0] Ins;
    logic        Ins_Valid;
    logic        Ins_Ready;
    logic [31:0] PC_Out;
    logic [31:0] PC4;
    logic        Redirect;
    logic [31:0] Redirect_Target;

    logic [31:0] key;
    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;

    assign Imem_Rdata = Imem_Addr ^ key;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
        .Imem_Ack(Imem_Ack), .Imem_Rdata(Imem_Rdata),
        .Ins(Ins), .Ins_Valid(Ins_Valid), .Ins_Ready(Ins_Ready),
        .PC_Out(PC_Out), .PC4(PC4),
        .Redirect(Redirect), .Redirect_Target(Redirect_Target)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    logic        m_idle, m_req, m_squash, m_valid;
    logic [31:0] m_pc, m_pend, m_ins, m_pcout, t;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_idle = 1'b1; m_req = 1'b0; m_squash = 1'b0; m_valid = 1'b0;
            m_pc = 32'h0; m_pend = 32'h0; m_ins = 32'h0; m_pcout = 32'h0;
        end else begin
            t = Redirect_Target & ~32'h3;
            if (m_idle) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
            end else if (m_req) begin
                if (Imem_Ack) begin
                    if (m_squash || Redirect) begin
                        m_pc     = Redirect ? t : m_pend;
                        m_squash = 1'b0;
                    end else begin
                        m_ins   = m_pc ^ key;
                        m_pcout = m_pc;
                        m_valid = 1'b1;
                        m_req   = 1'b0;
                    end
                end else if (Redirect) begin
                    m_squash = 1'b1;
                    m_pend   = t;
                end
            end else if (m_valid) begin
                if (Redirect || Ins_Ready) begin
                    m_pc    = Redirect ? t : m_pc + 32'd4;
                    m_valid = 1'b0;
                    m_req   = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_req", {31'd0, Imem_Req}, {31'd0, m_req});
            chk("m_valid", {31'd0, Ins_Valid}, {31'd0, m_valid});
            if (m_req) chk("m_addr", Imem_Addr, m_pc);
            if (m_valid) begin
                chk("m_ins", Ins, m_ins);
                chk("m_pcout", PC_Out, m_pcout);
                chk("m_pc4", PC4, m_pcout + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", {31'd0, Imem_Req}, 32'd0);
        chk("rst_addr", Imem_Addr, 32'h0);
        chk("rst_ins", Ins, 32'h0);
        chk("rst_valid", {31'd0, Ins_Valid}, 32'd0);
        chk("rst_pcout", PC_Out, 32'h0);
        chk("rst_pc4", PC4, 32'h4);
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b0;
        tick();
        tick();
        chk_reset_vals();
        RST = 1'b1;
    endtask

    logic [31:0] seen[$];

    initial begin
        RST = 1'b1; Imem_Ack = 1'b0; Ins_Ready = 1'b0; Redirect = 1'b0;
        Redirect_Target = 32'h0; key = 32'h1234_5678;
        #1 RST = 1'b0;
        #1 chk_en = 1'b1;

        // Ack tied high, ready high: address stream 0,4,8.
        Imem_Ack = 1'b1; Ins_Ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Imem_Req) seen.push_back(Imem_Addr);
        end
        chk("seq_n", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            chk("seq0", seen[0], 32'h0);
            chk("seq1", seen[1], 32'h4);
            chk("seq2", seen[2], 32'h8);
        end

        // Three-cycle memory wait at 0x0, then a five-cycle decode stall.
        Imem_Ack = 1'b0; Ins_Ready = 1'b0; key = 32'h2009_0011;
        do_reset();
        tick();
        chk("wait_req0", {31'd0, Imem_Req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'd0, Imem_Req}, 32'd1);
            chk("wait_addr", Imem_Addr, 32'h0);
            chk("wait_valid", {31'd0, Ins_Valid}, 32'd0);
        end
        Imem_Ack = 1'b1;
        tick();
        Imem_Ack = 1'b0;
        chk("ack_valid", {31'd0, Ins_Valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ins", Ins, 32'h2009_0011);
            chk("stall_pcout", PC_Out, 32'h0);
            chk("stall_valid", {31'd0, Ins_Valid}, 32'd1);
            chk("stall_req", {31'd0, Imem_Req}, 32'd0);
        end

        // Redirect during HOLD; low target bits dropped.
        Redirect = 1'b1; Redirect_Target = 32'h0000_0103;
        tick();
        chk("hold_redir_valid", {31'd0, Ins_Valid}, 32'd0);
        chk("hold_redir_addr", Imem_Addr, 32'h0000_0100);

        // Redirect on the ack edge: data dropped, refetch at 0x8.
        Imem_Ack = 1'b1; Redirect_Target = 32'h8;
        tick();
        chk("ackredir_addr", Imem_Addr, 32'h8);
        chk("ackredir_valid", {31'd0, Ins_Valid}, 32'd0);
        // Two redirects while 0x8 is outstanding; the later one wins.
        Imem_Ack = 1'b0; Redirect_Target = 32'h40;
        tick();
        chk("drain_addr0", Imem_Addr, 32'h8);
        Redirect_Target = 32'h80;
        tick();
        chk("drain_addr1", Imem_Addr, 32'h8);
        Redirect = 1'b0;
        tick();
        chk("drain_addr2", Imem_Addr, 32'h8);
        chk("drain_req", {31'd0, Imem_Req}, 32'd1);
        Imem_Ack = 1'b1;
        tick();
        chk("drain_done_addr", Imem_Addr, 32'h80);
        chk("drain_done_valid", {31'd0, Ins_Valid}, 32'd0);

        // PC wrap at the top of the address space.
        Redirect = 1'b1; Redirect_Target = 32'hFFFF_FFFF;
        tick();
        Redirect = 1'b0; Ins_Ready = 1'b1;
        tick();
        chk("wrap_pcout", PC_Out, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC4, 32'h0);
        tick();
        chk("wrap_addr", Imem_Addr, 32'h0);
        chk("wrap_req", {31'd0, Imem_Req}, 32'd1);

        // Reset mid-fetch takes effect immediately.
        Imem_Ack = 1'b0;
        tick();
        RST = 1'b0;
        #1 chk_reset_vals();
        tick();
        RST = 1'b1;

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            Imem_Ack        = ($urandom_range(0, 2) == 0);
            Ins_Ready       = $urandom_range(0, 1);
            Redirect        = ($urandom_range(0, 7) == 0);
            Redirect_Target = $urandom();
            key             = $urandom();
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b0;
                #1 chk_reset_vals();
            end else begin
                RST = 1'b1;
            end
            tick();
        end
        RST = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
